sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised-depth, parametrised-width circular-buffer FIFO. Next generation of the capture-path FIFO.
- Replaces shift-register storage with read/write pointers.
- Adds a valid/ready-style push/pop handshake, programmable almost-full/almost-empty thresholds, a live occupancy count, sticky overflow/underflow flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the pixel/frame capture logic and downstream consumers in the image capture datapath.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- FIFO_DEPTH, 8, number of entries; must be a power of two and >= 2.
- ALMOST_FULL_LEVEL, 6, almost_full asserts when count >= this value; legal range 1..FIFO_DEPTH.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when count <= this value; legal range 0..FIFO_DEPTH-1.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- Derived localparams: ADDR_WIDTH = clog2(FIFO_DEPTH); COUNT_WIDTH = ADDR_WIDTH+1.

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- clear  input  1  synchronous, active-high reset; flushes the FIFO.
- enable  input  1  when low, push/pop are ignored and state is held.
- push  input  1  write request.
- in_data  input  DATA_WIDTH  write data, sampled when a push is accepted.
- push_ready  output  1  = enable & ~full; a push is accepted only when push & push_ready.
- pop  input  1  read request.
- out_data  output  DATA_WIDTH  read data.
- out_valid  output  1  read data qualifier (meaning depends on mode).
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL.
- data_count  output  COUNT_WIDTH  current occupancy.
- pushed_last  output  1  1-cycle pulse: an accepted push made the FIFO full.
- popped_last  output  1  1-cycle pulse: an accepted pop made the FIFO empty.
- overflow  output  1  sticky: a push was attempted while full (with enable high).
- underflow  output  1  sticky: a pop was attempted while empty (with enable high).

Behaviour:
- Reset (clear=1 at a clock edge) sets:
  - pointers = 0, data_count = 0;
  - out_data = 0, out_valid = 0;
  - pushed_last = popped_last = 0, overflow = underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = (ALMOST_FULL_LEVEL == 0 ? n/a : 0).
  - clear overrides push/pop in the same cycle. A clear mid-operation discards all contents; storage RAM is not zeroed.
- Accept rules:
  - push_acc = enable & push & ~full.
  - pop_acc = enable & pop & ~empty.
  - Status is evaluated on pre-edge registered count, so a push and a pop in the same cycle never see each other's effect.
- Write: on push_acc, mem[wr_ptr] <= in_data; wr_ptr increments modulo FIFO_DEPTH (natural wrap at ADDR_WIDTH).
- Read: on pop_acc, rd_ptr increments modulo FIFO_DEPTH.
- Count:
  - +1 on push_acc only; -1 on pop_acc only.
  - Unchanged on both or neither.
  - Never exceeds FIFO_DEPTH and never underflows.
- Simultaneous push and pop:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: pop accepted, push rejected (push_ready = 0), overflow set.
  - Empty: push accepted, pop rejected, underflow set; no data bypass.
- All status flags are combinational from the registered count, so they change the cycle after the causing edge.
- pushed_last: registered; 1 for exactly one cycle after an edge where push_acc & ~pop_acc & count == FIFO_DEPTH-1.
- popped_last: registered; 1 for exactly one cycle after an edge where pop_acc & ~push_acc & count == 1.
- FWFT=0 (standard read):
  - On pop_acc, out_data <= mem[rd_ptr] and out_valid pulses 1 for the following cycle.
  - out_data holds its last value until the next accepted pop.
  - A rejected pop leaves out_data unchanged and out_valid = 0.
- FWFT=1 (fall-through read):
  - out_data = mem[rd_ptr] and out_valid = ~empty.
  - The head word is visible the cycle after it is written into an empty FIFO.
  - pop_acc advances to the next word; out_data is don't-care when out_valid = 0.
- enable = 0: no pointer, count, pulse, or sticky-flag changes; pushed_last/popped_last return to 0; outputs otherwise hold.
- overflow/underflow: cleared only by clear.

Test Plan:
- Fill/drain, FIFO_DEPTH=8, FWFT=0:
  - Push 0x11..0x88 on 8 consecutive cycles → full=1, data_count=8, pushed_last pulses once after the 8th push, almost_full asserts after the 6th push.
  - Then 8 pops → out_data 0x11..0x88 in order, each with a 1-cycle out_valid; popped_last pulses after the 8th pop; empty=1.
- Wrap-around:
  - Push 5, pop 5, then push 8 distinct words and pop 8 → output order intact across the pointer wrap; data_count peaks at 8.
- Simultaneous push+pop:
  - At count=4: push and pop held together for 10 cycles → data_count stays 4; data order preserved.
  - At full: push+pop together → pop accepted, overflow=1, count becomes 7.
  - At empty: push+pop together → push accepted, underflow=1, count becomes 1.
- Error/sticky:
  - Push while full → overflow=1, contents unchanged, stays set through later traffic until clear.
  - Pop while empty → underflow=1, out_data unchanged.
- FWFT=1:
  - Push 0xA5 into empty → next cycle out_valid=1, out_data=0xA5.
  - pop → out_valid=0 next cycle.
- Mid-operation clear and enable:
  - With count=5, assert clear for 1 cycle concurrent with push → count=0, empty=1, all flags 0, next push/pop works normally.
  - With enable=0 and push/pop toggling → no state change.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock circular-buffer FIFO with push/pop handshake, occupancy status,
// sticky error flags and a selectable standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = 6,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter bit FWFT               = 1'b0
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          push_ready,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   data_count,
    output logic                          pushed_last,
    output logic                          popped_last,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic                   push_acc;
    logic                   pop_acc;

    // Status comes from the registered count only, so a push and a pop in the
    // same cycle are judged against the same pre-edge occupancy.
    assign full         = (count == COUNT_WIDTH'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= COUNT_WIDTH'(ALMOST_FULL_LEVEL));
    assign almost_empty = (count <= COUNT_WIDTH'(ALMOST_EMPTY_LEVEL));
    assign data_count   = count;

    assign push_ready = enable & ~full;
    assign push_acc   = push & push_ready;
    assign pop_acc    = enable & pop & ~empty;

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pushed_last <= 1'b0;
            popped_last <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

            case ({push_acc, pop_acc})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase

            pushed_last <= push_acc & ~pop_acc & (count == COUNT_WIDTH'(FIFO_DEPTH - 1));
            popped_last <= pop_acc & ~push_acc & (count == COUNT_WIDTH'(1));

            if (enable & push & full)  overflow  <= 1'b1;
            if (enable & pop  & empty) underflow <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left out of the clear so it maps
    // onto plain RAM; the pointers and count alone define which words are live.
    always_ff @(posedge clock) begin
        if (push_acc & ~clear) mem[wr_ptr] <= in_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign out_data  = mem[rd_ptr];
            assign out_valid = ~empty;
        end else begin : g_std
            always_ff @(posedge clock) begin
                if (clear) begin
                    out_data  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= pop_acc;
                    if (pop_acc) out_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a standard and an FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clock;
    logic          clear, enable, push, pop;
    logic [DW-1:0] in_data;

    logic          push_ready, out_valid, full, empty, almost_full, almost_empty;
    logic          pushed_last, popped_last, overflow, underflow;
    logic [DW-1:0] out_data;
    logic [3:0]    data_count;

    logic          f_push_ready, f_out_valid, f_full, f_empty, f_almost_full, f_almost_empty;
    logic          f_pushed_last, f_popped_last, f_overflow, f_underflow;
    logic [DW-1:0] f_out_data;
    logic [3:0]    f_data_count;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AF),
                     .ALMOST_EMPTY_LEVEL(AE), .FWFT(1'b0)) dut (
        .clock(clock), .clear(clear), .enable(enable), .push(push), .in_data(in_data),
        .push_ready(push_ready), .pop(pop), .out_data(out_data), .out_valid(out_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .data_count(data_count), .pushed_last(pushed_last), .popped_last(popped_last),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AF),
                     .ALMOST_EMPTY_LEVEL(AE), .FWFT(1'b1)) dut_f (
        .clock(clock), .clear(clear), .enable(enable), .push(push), .in_data(in_data),
        .push_ready(f_push_ready), .pop(pop), .out_data(f_out_data), .out_valid(f_out_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .data_count(f_data_count), .pushed_last(f_pushed_last), .popped_last(f_popped_last),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the FIFO contents as a queue plus the observable registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_out;
    bit            m_valid, m_ovf, m_udf, m_pl, m_ppl;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit e, input bit c, input bit pu, input bit po,
                              input logic [DW-1:0] d);
        int  sz;
        bit  pa, pp;
        if (c) begin
            q.delete();
            m_out = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_pl = 0; m_ppl = 0;
            return;
        end
        sz = q.size();
        pa = e && pu && (sz != DEPTH);
        pp = e && po && (sz != 0);
        if (e && pu && sz == DEPTH) m_ovf = 1;
        if (e && po && sz == 0)     m_udf = 1;
        m_pl  = pa && !pp && (sz == DEPTH - 1);
        m_ppl = pp && !pa && (sz == 1);
        m_valid = pp;
        if (pp) m_out = q.pop_front();
        if (pa) q.push_back(d);
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        check("data_count",   data_count,   sz);
        check("full",         full,         sz == DEPTH);
        check("empty",        empty,        sz == 0);
        check("almost_full",  almost_full,  sz >= AF);
        check("almost_empty", almost_empty, sz <= AE);
        check("push_ready",   push_ready,   enable && (sz != DEPTH));
        check("out_valid",    out_valid,    m_valid);
        check("out_data",     out_data,     m_out);
        check("pushed_last",  pushed_last,  m_pl);
        check("popped_last",  popped_last,  m_ppl);
        check("overflow",     overflow,     m_ovf);
        check("underflow",    underflow,    m_udf);
        check("f_data_count", f_data_count, sz);
        check("f_out_valid",  f_out_valid,  sz != 0);
        if (sz != 0) check("f_out_data", f_out_data, q[0]);
        check("f_overflow",   f_overflow,   m_ovf);
        check("f_underflow",  f_underflow,  m_udf);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1 ns later.
    task automatic apply(input bit e, input bit c, input bit pu, input bit po,
                         input logic [DW-1:0] d);
        enable = e; clear = c; push = pu; pop = po; in_data = d;
        @(posedge clock);
        model_step(e, c, pu, po, d);
        #1;
        check_model();
    endtask

    typedef struct {
        bit            push;
        bit            pop;
        logic [DW-1:0] din;
        int            e_count;
        bit            e_full;
        bit            e_empty;
        bit            e_af;
        bit            e_pl;
        bit            e_ppl;
        bit            e_ov;
        logic [DW-1:0] e_od;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int bias;

        // Fill/drain vectors: push 0x11..0x88, then pop them back in order.
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b1, 1'b0, 32'h11 * (k + 1), k + 1, k == 7, 1'b0,
                        (k + 1) >= 6, k == 7, 1'b0, 1'b0, 32'h0};
        for (int j = 0; j < 8; j++)
            vecs[8 + j] = '{1'b0, 1'b1, 32'h0, 7 - j, 1'b0, j == 7,
                            (7 - j) >= 6, 1'b0, j == 7, 1'b1, 32'h11 * (j + 1)};

        enable = 0; clear = 1; push = 0; pop = 0; in_data = '0;
        apply(0, 1, 0, 0, 0);
        apply(1, 1, 1, 1, 32'hFFFF);
        check("reset_empty", empty, 1'b1);
        check("reset_count", data_count, 4'd0);

        for (int i = 0; i < 16; i++) begin
            apply(1, 0, vecs[i].push, vecs[i].pop, vecs[i].din);
            check("vec_count",       data_count,  vecs[i].e_count);
            check("vec_full",        full,        vecs[i].e_full);
            check("vec_empty",       empty,       vecs[i].e_empty);
            check("vec_almost_full", almost_full, vecs[i].e_af);
            check("vec_pushed_last", pushed_last, vecs[i].e_pl);
            check("vec_popped_last", popped_last, vecs[i].e_ppl);
            check("vec_out_valid",   out_valid,   vecs[i].e_ov);
            check("vec_out_data",    out_data,    vecs[i].e_od);
        end

        // Wrap-around: offset the pointers by 5, then cycle a full FIFO through.
        for (int i = 0; i < 5; i++) apply(1, 0, 1, 0, 32'h50 + i);
        for (int i = 0; i < 5; i++) apply(1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) apply(1, 0, 1, 0, 32'h100 + i);
        check("wrap_peak_count", data_count, 4'd8);
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, 1, 0);
            check("wrap_order", out_data, 32'h100 + i);
        end

        // Simultaneous push+pop at count 4 keeps occupancy steady and order intact.
        for (int i = 0; i < 4; i++) apply(1, 0, 1, 0, 32'h200 + i);
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 1, 1, 32'h300 + i);
            check("pp_count", data_count, 4'd4);
            check("pp_order", out_data, (i < 4) ? 32'h200 + i : 32'h300 + (i - 4));
        end
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 1, 0);

        // Push+pop while full: only the pop is taken.
        apply(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply(1, 0, 1, 0, 32'h400 + i);
        apply(1, 0, 1, 1, 32'hBAD);
        check("full_pp_count", data_count, 4'd7);
        check("full_pp_ovf",   overflow, 1'b1);
        check("full_pp_data",  out_data, 32'h400);

        // Push+pop while empty: only the push is taken.
        apply(1, 1, 0, 0, 0);
        apply(1, 0, 1, 1, 32'h600);
        check("empty_pp_count", data_count, 4'd1);
        check("empty_pp_udf",   underflow, 1'b1);
        check("empty_pp_valid", out_valid, 1'b0);

        // Push while full sets a sticky overflow that survives traffic until clear.
        apply(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply(1, 0, 1, 0, 32'h700 + i);
        apply(1, 0, 1, 0, 32'hDEAD);
        check("ovf_set",   overflow, 1'b1);
        check("ovf_count", data_count, 4'd8);
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, 1, 0);
            check("ovf_contents", out_data, 32'h700 + i);
        end
        check("ovf_sticky", overflow, 1'b1);
        apply(1, 1, 0, 0, 0);
        check("ovf_cleared", overflow, 1'b0);

        // Pop while empty sets underflow and leaves out_data alone.
        apply(1, 0, 1, 0, 32'h77);
        apply(1, 0, 0, 1, 0);
        apply(1, 0, 0, 1, 0);
        check("udf_set",   underflow, 1'b1);
        check("udf_data",  out_data, 32'h77);
        check("udf_valid", out_valid, 1'b0);

        // FWFT: head word appears the cycle after the write, and drops after the pop.
        apply(1, 1, 0, 0, 0);
        apply(1, 0, 1, 0, 32'hA5);
        check("fwft_valid", f_out_valid, 1'b1);
        check("fwft_data",  f_out_data, 32'hA5);
        apply(1, 0, 0, 1, 0);
        check("fwft_valid_after_pop", f_out_valid, 1'b0);

        // Clear with a concurrent push at count 5 flushes everything.
        for (int i = 0; i < 5; i++) apply(1, 0, 1, 0, 32'h800 + i);
        apply(1, 1, 1, 0, 32'h99);
        check("mclr_count", data_count, 4'd0);
        check("mclr_empty", empty, 1'b1);
        check("mclr_ovf",   overflow, 1'b0);
        check("mclr_udf",   underflow, 1'b0);
        apply(1, 0, 1, 0, 32'h55);
        apply(1, 0, 0, 1, 0);
        check("mclr_after", out_data, 32'h55);

        // enable low freezes the FIFO whatever push/pop do.
        for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 32'h900 + i);
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, i[0], i[1], 32'hEE);
            check("en_count", data_count, 4'd3);
            check("en_ready", push_ready, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 1, 0);
            check("en_order", out_data, 32'h900 + i);
        end

        // Randomized traffic with phases biased toward filling and draining.
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) bias = 20 + 30 * $urandom_range(0, 2);
            apply($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
